spi_mem_fsm: RTL and testbench

Transaction sequencer for the SPI memory slave. It counts conditioned SCLK edges while chip select is active and decodes the 7-bit address plus R/W bit. It then drives the enables of the address latch, the shift-register parallel load, the data-memory write and the MISO output flop and tri-state buffer. It sits between the input conditioners and the datapath, and is the only source of those enables.

---
 rtl/spi_mem_pkg.sv | 34 +++
 rtl/spi_mem_if.sv | 29 ++
 rtl/spi_bit_counter.sv | 26 ++
 rtl/spi_mem_fsm.sv | 130 +++++++++++++
 tb/tb_spi_mem_fsm.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and defaults for the SPI memory transaction sequencer.
// State set grows by INC when SPI_MEM_FSM_BURST_EN is defined.
package spi_mem_pkg;

    localparam int ADDR_BITS_DEF = 7;
    localparam int DATA_BITS_DEF = 8;
    localparam int CNT_W         = 4;

`ifdef SPI_MEM_FSM_BURST_EN
    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_STORE,
        DONE,
        INC
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_GET,
        WRITE_STORE,
        DONE
    } state_t;
`endif

endpackage

// File: rtl/spi_mem_if.sv
// Sequencer bundle: conditioned SPI inputs in, datapath enables out.
// master = sequencer side, slave = conditioner/datapath side.
interface spi_mem_if;

    logic cs_n;
    logic sclk_rise;
    logic sclk_fall;
    logic rw;
    logic addr_we;
    logic sr_we;
    logic dm_we;
    logic miso_ce;
    logic miso_buff;
    logic addr_inc;
    logic busy;

    modport master (
        input  cs_n, sclk_rise, sclk_fall, rw,
        output addr_we, sr_we, dm_we, miso_ce,
        output miso_buff, addr_inc, busy
    );

    modport slave (
        output cs_n, sclk_rise, sclk_fall, rw,
        input  addr_we, sr_we, dm_we, miso_ce,
        input  miso_buff, addr_inc, busy
    );

endinterface

// File: rtl/spi_bit_counter.sv
// SCLK bit counter with synchronous clear, enable and terminal-count flag.
module spi_bit_counter
    import spi_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    // Fires on the increment that reaches tc_val, so the FSM leaves on that edge.
    assign tc = en && ((cnt + 1'b1) == tc_val);

endmodule

// File: rtl/spi_mem_fsm.sv
// SPI memory slave transaction sequencer; sole source of datapath enables.
// Define SPI_MEM_FSM_BURST_EN for auto-incrementing burst transfers.
module spi_mem_fsm
    import spi_mem_pkg::*;
#(
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input logic       clk,
    input logic       rst_n,
    spi_mem_if.master bus
);

    localparam logic [CNT_W-1:0] ADDR_TC = CNT_W'(ADDR_BITS + 1);
    localparam logic [CNT_W-1:0] DATA_TC = CNT_W'(DATA_BITS);

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] tc_val;
    logic             cnt_en;
    logic             cnt_clr;
    logic             tc;
    logic             addr_we;
    logic             sr_we;
    logic             dm_we;
    logic             miso_ce;
    logic             miso_buff;
    logic             addr_inc;

    // Chip-select release blocks counting so an abort never advances the count.
    assign cnt_en = bus.sclk_rise && !bus.cs_n &&
                    (state == GET_ADDR || state == READ_SHIFT ||
                     state == WRITE_GET);
    assign tc_val  = (state == GET_ADDR) ? ADDR_TC : DATA_TC;
    assign cnt_clr = (nxt != state);

    spi_bit_counter u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (tc_val),
        .cnt    (bit_cnt),
        .tc     (tc)
    );

`ifdef SPI_MEM_FSM_BURST_EN
    logic rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= 1'b0;
        else if (state == GOT_ADDR)
            rd_q <= bus.rw;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt       = state;
        addr_we   = 1'b0;
        sr_we     = 1'b0;
        dm_we     = 1'b0;
        miso_ce   = 1'b0;
        miso_buff = 1'b0;
        addr_inc  = 1'b0;
        unique case (state)
            IDLE:
                if (!bus.cs_n) nxt = GET_ADDR;
            GET_ADDR:
                if (tc) nxt = GOT_ADDR;
            GOT_ADDR: begin
                addr_we = 1'b1;
                nxt     = bus.rw ? READ_LOAD : WRITE_GET;
            end
            READ_LOAD: begin
                sr_we     = 1'b1;
                miso_buff = 1'b1;
                nxt       = READ_SHIFT;
            end
            READ_SHIFT: begin
                miso_buff = 1'b1;
                miso_ce   = bus.sclk_fall;
`ifdef SPI_MEM_FSM_BURST_EN
                if (tc) nxt = INC;
`else
                if (tc) nxt = DONE;
`endif
            end
            WRITE_GET:
                if (tc) nxt = WRITE_STORE;
            WRITE_STORE: begin
                dm_we = 1'b1;
`ifdef SPI_MEM_FSM_BURST_EN
                nxt   = INC;
`else
                nxt   = DONE;
`endif
            end
            DONE:
                nxt = DONE;
`ifdef SPI_MEM_FSM_BURST_EN
            INC: begin
                addr_inc = 1'b1;
                nxt      = rd_q ? READ_LOAD : WRITE_GET;
            end
`endif
            default:
                nxt = IDLE;
        endcase
        if (bus.cs_n && state != IDLE)
            nxt = IDLE;
    end

    assign bus.addr_we   = addr_we;
    assign bus.sr_we     = sr_we;
    assign bus.dm_we     = dm_we;
    assign bus.miso_ce   = miso_ce;
    assign bus.miso_buff = miso_buff;
    assign bus.addr_inc  = addr_inc;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_mem_fsm.sv
// Directed bench for spi_mem_fsm with an event scoreboard.
// Build with +define+SPI_MEM_FSM_BURST_EN to exercise burst expectations.
module tb_spi_mem_fsm;

`ifdef SPI_MEM_FSM_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int EV_ADDR = 1;
    localparam int EV_SR   = 2;
    localparam int EV_DM   = 3;
    localparam int EV_INC  = 4;

    typedef struct packed {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   mce = 0;
    int   mce_bad = 0;
    int   brise = 0;
    ev_t  obs[$];
    ev_t  exp_q[$];

    spi_mem_if bus ();

    spi_mem_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every enable cycle with its cycle stamp; miso checks are tallied.
    always @(negedge clk) begin
        if (bus.addr_we)  obs.push_back('{EV_ADDR, cyc});
        if (bus.sr_we)    obs.push_back('{EV_SR, cyc});
        if (bus.dm_we)    obs.push_back('{EV_DM, cyc});
        if (bus.addr_inc) obs.push_back('{EV_INC, cyc});
        if (bus.miso_ce) begin
            mce++;
            if (!bus.sclk_fall) mce_bad++;
        end
        if (bus.sclk_rise && bus.miso_buff) brise++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, bus.addr_we, bus.sr_we, bus.dm_we, bus.miso_ce,
                bus.miso_buff, bus.addr_inc, bus.busy};
    endfunction

    task automatic drain(input string tag);
        ev_t e;
        ev_t o;
        repeat (3) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{-1, -1};
            if (obs.size() > 0) o = obs.pop_front();
            total++;
            assert (o === e) else begin
                bad++;
                $error("FAIL %s ev: observed=k%0d@%0d expected=k%0d@%0d",
                       tag, o.kind, o.cyc, e.kind, e.cyc);
            end
        end
        total++;
        assert (obs.size() === 0) else begin
            bad++;
            $error("FAIL %s extra: observed=%0d events expected=0 (k%0d@%0d)",
                   tag, obs.size(), obs[0].kind, obs[0].cyc);
        end
        obs.delete();
    endtask

    task automatic spi_bit(input logic b, output int rc);
        @(posedge clk);
        #1;
        bus.sclk_rise = 1'b1;
        bus.rw = b;
        rc = cyc;
        @(posedge clk);
        #1 bus.sclk_rise = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 bus.sclk_fall = 1'b1;
        @(posedge clk);
        #1 bus.sclk_fall = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] v, output int rc);
        for (int i = 7; i >= 0; i--) spi_bit(v[i], rc);
    endtask

    task automatic cs_high_idle(input string tag);
        @(posedge clk);
        #1 bus.cs_n = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_hold"}, bus.busy, 1);
        @(posedge clk);
        #1;
        chk({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic full_write(input string tag);
        int rc;
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        shift_byte(8'h24, rc);
        exp_q.push_back('{EV_ADDR, rc + 1});
        shift_byte(8'hA5, rc);
        exp_q.push_back('{EV_DM, rc + 1});
        if (BURST) exp_q.push_back('{EV_INC, rc + 2});
        repeat (2) @(posedge clk);
        cs_high_idle(tag);
        drain(tag);
    endtask

    initial begin
        int rc;
        int m0;
        int mb0;
        int b0;
        rst_n = 1'b0;
        bus.cs_n = 1'b1;
        bus.sclk_rise = 1'b0;
        bus.sclk_fall = 1'b0;
        bus.rw = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs(), 0);
        chk("reset_cnt", dut.bit_cnt, 0);
        rst_n = 1'b1;

        full_write("write");

        // read 0x12
        m0 = mce;
        mb0 = mce_bad;
        b0 = brise;
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        shift_byte(8'h25, rc);
        exp_q.push_back('{EV_ADDR, rc + 1});
        exp_q.push_back('{EV_SR, rc + 2});
        shift_byte(8'h3C, rc);
        if (BURST) begin
            exp_q.push_back('{EV_INC, rc + 1});
            exp_q.push_back('{EV_SR, rc + 2});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("read_mce_cnt", mce - m0, BURST ? 9 : 8);
        chk("read_mce_nofall", mce_bad - mb0, 0);
        chk("read_buff_rises", brise - b0, 8);
        cs_high_idle("read");
        drain("read");

        // abort after 4 address rises
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        for (int i = 0; i < 4; i++) spi_bit(1'b1, rc);
        @(negedge clk);
        chk("abort_cnt4", dut.bit_cnt, 4);
        cs_high_idle("abort");
        chk("abort_cnt0", dut.bit_cnt, 0);
        drain("abort");

        // async reset mid-write
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        shift_byte(8'h24, rc);
        exp_q.push_back('{EV_ADDR, rc + 1});
        for (int i = 0; i < 3; i++) spi_bit(1'b1, rc);
        @(negedge clk);
        chk("rst_busy_before", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outs", outs(), 0);
        chk("rst_async_cnt", dut.bit_cnt, 0);
        bus.cs_n = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drain("rst");
        full_write("rewrite");

        // 8th address rise coincident with cs_n release
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        for (int i = 0; i < 7; i++) spi_bit(1'b0, rc);
        @(posedge clk);
        #1;
        bus.sclk_rise = 1'b1;
        bus.cs_n = 1'b1;
        @(posedge clk);
        #1 bus.sclk_rise = 1'b0;
        chk("simul_idle", bus.busy, 0);
        chk("simul_cnt", dut.bit_cnt, 0);
        drain("simul");

        // header + 3 data bytes
        @(posedge clk);
        #1 bus.cs_n = 1'b0;
        shift_byte(8'h24, rc);
        exp_q.push_back('{EV_ADDR, rc + 1});
        for (int k = 0; k < 3; k++) begin
            shift_byte(8'h5A ^ 8'(k), rc);
            if (BURST) begin
                exp_q.push_back('{EV_DM, rc + 1});
                exp_q.push_back('{EV_INC, rc + 2});
            end else if (k == 0) begin
                exp_q.push_back('{EV_DM, rc + 1});
            end
        end
        repeat (2) @(posedge clk);
        cs_high_idle("burst");
        drain("burst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
